// File: rtl/fft_result_reader_pkg.sv
// Shared constants and helpers for the FFT result reader.
// Holds the FSM state encodings and the clog2 helper used to size addresses.
package fft_result_reader_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage |x|^2 datapath: squares registered first, then their unsigned sum.
// The stall enable freezes both stages together; it contains no control logic.
module fft_mag_sq #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] re,
  input  logic signed [DATA_WIDTH-1:0] im,
  output logic [2*DATA_WIDTH-1:0]      mag
);

  localparam int unsigned MagWidth = 2 * DATA_WIDTH;

  logic signed [MagWidth-1:0] sq_re_q;
  logic signed [MagWidth-1:0] sq_im_q;

  // Sign-extend before multiplying so the product is a full-width signed square.
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_re_q <= '0;
      sq_im_q <= '0;
      mag     <= '0;
    end else if (enable) begin
      sq_re_q <= MagWidth'(re) * MagWidth'(re);
      sq_im_q <= MagWidth'(im) * MagWidth'(im);
      mag     <= $unsigned(sq_re_q) + $unsigned(sq_im_q);
    end
  end

endmodule

// File: rtl/fft_result_reader.sv
// Streams FFT result-RAM contents out as power (re^2 + im^2) beats with backpressure.
// Define FFT_READER_HALF_EN to read only the first N/2 bins (real-input spectrum).
module fft_result_reader
  import fft_result_reader_pkg::*;
#(
  parameter int unsigned N          = 1024,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fft_done,
  output logic [ADDR_WIDTH-1:0]        addr_rd,
  input  logic signed [DATA_WIDTH-1:0] o_real,
  input  logic signed [DATA_WIDTH-1:0] o_img,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [2*DATA_WIDTH-1:0]      m_data,
  output logic [ADDR_WIDTH-1:0]        m_index,
  output logic                         m_last,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned MagWidth = 2 * DATA_WIDTH;
`ifdef FFT_READER_HALF_EN
  localparam int unsigned LastBinInt = N / 2 - 1;
`else
  localparam int unsigned LastBinInt = N - 1;
`endif
  localparam logic [ADDR_WIDTH-1:0] LastBin = ADDR_WIDTH'(LastBinInt);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  rd_v_q, rd_v_d;
  logic                  done_q;
  logic                  enable;
  logic                  accept;

  // Tags travel alongside the data: t1 matches the RAM output, t2 the square stage.
  logic                  t1_v_q, t2_v_q;
  logic [ADDR_WIDTH-1:0] t1_idx_q, t2_idx_q;

  // Skid copy of the RAM word visible in the first stall cycle; after that the
  // RAM shows the held address, which is one bin ahead of what the pipe needs.
  logic                         stall_q;
  logic signed [DATA_WIDTH-1:0] hold_re_q, hold_im_q;
  logic signed [DATA_WIDTH-1:0] mag_re, mag_im;
  logic [MagWidth-1:0]          mag;

  assign enable     = !(m_valid && !m_ready);
  assign accept     = m_valid && m_ready;
  assign frame_done = accept && m_last;
  assign busy       = (state_q != StIdle);
  assign m_data     = mag;
  assign mag_re     = stall_q ? hold_re_q : o_real;
  assign mag_im     = stall_q ? hold_im_q : o_img;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_rd;
    rd_v_d  = rd_v_q;
    case (state_q)
      StIdle: begin
        if (fft_done && !done_q) begin
          state_d = StRead;
          addr_d  = '0;
          rd_v_d  = 1'b1;
        end
      end
      StRead: begin
        if (enable) begin
          if (addr_rd == LastBin) begin
            state_d = StDrain;
            rd_v_d  = 1'b0;
          end else begin
            addr_d = addr_rd + 1'b1;
          end
        end
      end
      StDrain: begin
        if (frame_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_rd   <= '0;
      rd_v_q    <= 1'b0;
      done_q    <= 1'b1;
      stall_q   <= 1'b0;
      hold_re_q <= '0;
      hold_im_q <= '0;
      t1_v_q    <= 1'b0;
      t1_idx_q  <= '0;
      t2_v_q    <= 1'b0;
      t2_idx_q  <= '0;
      m_valid   <= 1'b0;
      m_index   <= '0;
      m_last    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_rd <= addr_d;
      rd_v_q  <= rd_v_d;
      done_q  <= fft_done;
      stall_q <= !enable;
      if (!enable && !stall_q) begin
        hold_re_q <= o_real;
        hold_im_q <= o_img;
      end
      if (enable) begin
        t1_v_q   <= rd_v_q;
        t1_idx_q <= addr_rd;
        t2_v_q   <= t1_v_q;
        t2_idx_q <= t1_idx_q;
        m_valid  <= t2_v_q;
        m_index  <= t2_idx_q;
        m_last   <= t2_v_q && (t2_idx_q == LastBin);
      end
    end
  end

  fft_mag_sq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mag_sq (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .re    (mag_re),
    .im    (mag_im),
    .mag   (mag)
  );

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: RAM model, beat scoreboard, stall and reset cases.
// Honours FFT_READER_HALF_EN so the same bench covers the half-spectrum build.
module tb_fft_result_reader;

  localparam int N  = 1024;
  localparam int DW = 16;
  localparam int AW = 10;
`ifdef FFT_READER_HALF_EN
  localparam int LAST = 511;
`else
  localparam int LAST = 1023;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 fft_done;
  logic [AW-1:0]        addr_rd;
  logic signed [DW-1:0] o_real;
  logic signed [DW-1:0] o_img;
  logic                 m_valid;
  bit                   m_ready;
  logic [2*DW-1:0]      m_data;
  logic [AW-1:0]        m_index;
  logic                 m_last;
  logic                 busy;
  logic                 frame_done;

  logic signed [DW-1:0] re_mem [N];
  logic signed [DW-1:0] im_mem [N];
  logic [2*DW-1:0]      exp_mem [N];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_idx  = 0;
  int  beat_cnt = 0;
  int  frame_cnt = 0;
  int  fd_cnt   = 0;
  int  stall_cnt = 0;
  bit  mon_en   = 1'b0;
  bit  rand_mode = 1'b0;
  bit  stall_seen = 1'b0;
  logic [AW-1:0] stall_addr, stall_idx;

  fft_result_reader #(
    .N         (N),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fft_done  (fft_done),
    .addr_rd   (addr_rd),
    .o_real    (o_real),
    .o_img     (o_img),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Result RAM: one-cycle read latency.
  always @(posedge clk) begin
    o_real <= re_mem[addr_rd];
    o_img  <= im_mem[addr_rd];
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) m_ready = ($urandom_range(0, 1) == 1);
    else           m_ready = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (stall_seen) begin
        check("stall_addr_hold", 64'(addr_rd), 64'(stall_addr));
        check("stall_idx_hold", 64'(m_index), 64'(stall_idx));
      end
      stall_seen = m_valid && !m_ready;
      stall_addr = addr_rd;
      stall_idx  = m_index;
      if (stall_seen) stall_cnt++;
      if (frame_done) fd_cnt++;
      if (m_valid && m_ready) begin
        check("beat_idx", 64'(m_index), 64'(exp_idx));
        check("beat_data", 64'(m_data), 64'(exp_mem[exp_idx]));
        check("beat_last", 64'(m_last), 64'(exp_idx == LAST));
        check("beat_fdone", 64'(frame_done), 64'(exp_idx == LAST));
        beat_cnt++;
        if (exp_idx == LAST) begin
          exp_idx = 0;
          frame_cnt++;
        end else begin
          exp_idx++;
        end
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  // Lower then raise fft_done; returns just after the edge that samples the rise.
  task automatic trigger();
    @(posedge clk); #1 fft_done = 1'b0;
    @(posedge clk); #1 fft_done = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_frame(input string tag, input int target, input int start_beats);
    int cyc;
    cyc = 0;
    while (frame_cnt < target && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_frame_seen"}, 64'(frame_cnt), 64'(target));
    check({tag, "_beats"}, 64'(beat_cnt - start_beats), 64'(LAST + 1));
  endtask

  initial begin
    int start;
    int cyc;
    reset    = 1'b1;
    fft_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      re_mem[i] = '0; im_mem[i] = '0; exp_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_addr", 64'(addr_rd), 0);
    check("rst_valid", 64'(m_valid), 0);
    check("rst_data", 64'(m_data), 0);
    check("rst_index", 64'(m_index), 0);
    check("rst_last", 64'(m_last), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_fdone", 64'(frame_done), 0);
    mon_en = 1'b1;

    // Constant spectrum, latency of first beat.
    for (int i = 0; i < N; i++) begin
      re_mem[i] = 16'sd100; im_mem[i] = 16'sd0; exp_mem[i] = 32'd10000;
    end
    start = beat_cnt;
    trigger();
    @(negedge clk);
    check("lat_addr0", 64'(addr_rd), 0);
    check("lat_busy", 64'(busy), 1);
    check("lat_novalid1", 64'(m_valid), 0);
    @(negedge clk);
    check("lat_addr1", 64'(addr_rd), 1);
    check("lat_novalid2", 64'(m_valid), 0);
    @(negedge clk);
    check("lat_novalid3", 64'(m_valid), 0);
    @(negedge clk);
    check("lat_first_valid", 64'(m_valid), 1);
    check("lat_first_idx", 64'(m_index), 0);
    check("lat_first_data", 64'(m_data), 64'd10000);
    wait_frame("const", 1, start);
    repeat (20) @(posedge clk);
    check("held_high_no_retrigger", 64'(frame_cnt), 1);
    check("held_high_idle", 64'(busy), 0);

    // Single full-scale bin; fft_done glitch mid-frame must be ignored.
    for (int i = 0; i < N; i++) begin
      re_mem[i] = (i == 5) ? -16'sd32768 : 16'sd0;
      im_mem[i] = (i == 5) ? -16'sd32768 : 16'sd0;
      exp_mem[i] = (i == 5) ? 32'd2147483648 : 32'd0;
    end
    start = beat_cnt;
    trigger();
    repeat (50) @(posedge clk);
    #1 fft_done = 1'b0;
    @(posedge clk); #1 fft_done = 1'b1;
    wait_frame("maxbin", 2, start);

    // Ramp under random backpressure.
    for (int i = 0; i < N; i++) begin
      re_mem[i] = DW'(i); im_mem[i] = DW'(-i); exp_mem[i] = 32'(2 * i * i);
    end
    start = beat_cnt;
    stall_cnt = 0;
    rand_mode = 1'b1;
    trigger();
    wait_frame("ramp", 3, start);
    rand_mode = 1'b0;
    check("ramp_stalls_seen", 64'(stall_cnt > 0), 1);

    // Reset mid-frame with fft_done held high, then restart.
    for (int i = 0; i < N; i++) begin
      re_mem[i] = 16'sd100; im_mem[i] = 16'sd0; exp_mem[i] = 32'd10000;
    end
    start = beat_cnt;
    trigger();
    cyc = 0;
    while (beat_cnt < start + 300 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("rst_mid_reached", 64'(beat_cnt - start >= 300), 1);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_idx = 0;
    @(negedge clk);
    check("rst_mid_valid", 64'(m_valid), 0);
    check("rst_mid_busy", 64'(busy), 0);
    check("rst_mid_addr", 64'(addr_rd), 0);
    check("rst_mid_data", 64'(m_data), 0);
    repeat (20) @(posedge clk);
    check("rst_high_no_trigger", 64'(busy), 0);
    start = beat_cnt;
    trigger();
    wait_frame("restart", 4, start);
    repeat (30) @(posedge clk);
    check("frame_done_pulses", 64'(fd_cnt), 4);
    check("final_idle", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
